// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Word-addressed PC, req/gnt instruction
// memory interface with in-order responses, DEPTH-entry prefetch queue with a
// registered head, and redirect handling that drops stale in-flight responses.
module fetch_unit #(
  parameter int          INSTR_W  = 17,
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               PCSrc,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc, resp_pc;
  logic [CW-1:0]      count, outstanding, drop_cnt;
  logic [INSTR_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0]  q_pc   [DEPTH];

  logic [CW:0]   credit_used;
  logic          fire, resp, drop, push, pop;
  logic [CW-1:0] out_nxt, drop_nxt, wr_full;
  logic [CW-2:0] wr_idx;

  // Credit counts both buffered words and words still in flight, so every
  // granted request is guaranteed a queue slot when it returns.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = (state != BOOT) && (credit_used < (CW+1)'(DEPTH)) && !PCSrc;
  assign imem_addr   = fetch_pc;

  assign fire = imem_req && imem_gnt;
  // A response with nothing tracked belongs to requests abandoned by reset.
  assign resp = imem_rvalid && (outstanding != '0);
  assign drop = resp && (drop_cnt != '0);
  assign push = resp && (drop_cnt == '0) && !PCSrc;
  assign pop  = instr_valid && instr_ready;

  assign out_nxt  = outstanding + CW'(fire) - CW'(resp);
  // On redirect every request still in flight after this cycle is stale.
  assign drop_nxt = PCSrc ? out_nxt : (drop_cnt - CW'(drop));

  assign wr_full = pop ? (count - CW'(1)) : count;
  assign wr_idx  = wr_full[CW-2:0];

  assign instr_valid = (count != '0);
  assign instr       = q_data[0];
  assign instr_pc    = q_pc[0];

  // FSM: one boot cycle, then RUN, or DRAIN while stale responses remain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT, RUN, DRAIN: state <= (drop_nxt != '0) ? DRAIN : RUN;
        default:          state <= BOOT;
      endcase
    end
  end

  // Fetch/response address tracking and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      resp_pc     <= ADDR_W'(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      if (PCSrc) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (fire) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (push) resp_pc  <= resp_pc + ADDR_W'(1);
      end
    end
  end

  // Shift queue: entry 0 is the registered head; push lands after the last
  // valid entry (one slot lower when a pop shifts the queue this cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (PCSrc) begin
      count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        for (int i = 0; i < DEPTH-1; i++) begin
          q_data[i] <= q_data[i+1];
          q_pc[i]   <= q_pc[i+1];
        end
      end
      if (push) begin
        q_data[wr_idx] <= imem_rdata;
        q_pc[wr_idx]   <= resp_pc;
      end
    end
  end

endmodule
